// File: rtl/dst7_8_acc.sv
// Accumulation stage behind the 8-point DST-VII shift-add unit. It sums the selected signed
// products of eight samples, then presents a rounded and saturated result under valid/ready.
module dst7_8_acc #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 36,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  P1,
  input  logic signed [IN_W-1:0]  P2,
  input  logic signed [IN_W-1:0]  P3,
  input  logic signed [IN_W-1:0]  P4,
  input  logic signed [IN_W-1:0]  P5,
  input  logic signed [IN_W-1:0]  P6,
  input  logic signed [IN_W-1:0]  P7,
  input  logic signed [IN_W-1:0]  P8,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] Y0,
  output logic signed [OUT_W-1:0] Y1,
  output logic signed [OUT_W-1:0] Y2,
  output logic signed [OUT_W-1:0] Y3,
  output logic signed [OUT_W-1:0] Y4,
  output logic signed [OUT_W-1:0] Y5,
  output logic signed [OUT_W-1:0] Y6,
  output logic signed [OUT_W-1:0] Y7
);

  localparam int RW  = ACC_W + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RSH) : {RW{1'b0}};

  typedef enum logic [0:0] {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

  state_t                   state_r;
  logic [2:0]               cnt_r;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic signed [ACC_W-1:0]  acc_r  [8];
  logic signed [ACC_W-1:0]  nxt_s  [8];
  logic signed [IN_W-1:0]   p_s    [8];
  logic signed [RW-1:0]     r_s    [8];
  logic signed [OUT_W-1:0]  y_s    [8];
  logic signed [OUT_W-1:0]  yo_s   [8];

  // Returns {negate, product index 0..7} for output k and sample n, from m = (2k+1)(n+1) mod 34.
  function automatic logic [3:0] sel_f(input int k, input logic [2:0] n);
    int m;
    logic [3:0] r;
    m = ((32'sd2 * k + 32'sd1) * (int'(n) + 32'sd1)) % 32'sd34;
    if (m <= 32'sd8) begin
      r = {1'b0, 3'(m - 32'sd1)};
    end else if (m <= 32'sd16) begin
      r = {1'b0, 3'(32'sd16 - m)};
    end else if (m <= 32'sd25) begin
      r = {1'b1, 3'(m - 32'sd18)};
    end else begin
      r = {1'b1, 3'(32'sd33 - m)};
    end
    return r;
  endfunction

  assign p_s[0] = P1;
  assign p_s[1] = P2;
  assign p_s[2] = P3;
  assign p_s[3] = P4;
  assign p_s[4] = P5;
  assign p_s[5] = P6;
  assign p_s[6] = P7;
  assign p_s[7] = P8;

  // Next accumulator values: add or subtract the sign-extended product chosen for (k, n).
  always_comb begin
    logic [3:0]              sel;
    logic signed [ACC_W-1:0] ext;
    for (int k = 0; k < 8; k++) begin
      sel = sel_f(k, cnt_r);
      ext = {{(ACC_W-IN_W){p_s[sel[2:0]][IN_W-1]}}, p_s[sel[2:0]]};
      if (sel[3]) begin
        nxt_s[k] = acc_r[k] - ext;
      end else begin
        nxt_s[k] = acc_r[k] + ext;
      end
    end
  end

  // Block state machine: accumulate eight accepted samples, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_ACC;
      cnt_r       <= 3'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      for (int k = 0; k < 8; k++) acc_r[k] <= '0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (in_valid && in_ready_r) begin
            for (int k = 0; k < 8; k++) acc_r[k] <= nxt_s[k];
            if (cnt_r == 3'd7) begin
              cnt_r       <= 3'd0;
              state_r     <= ST_OUT;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            for (int k = 0; k < 8; k++) acc_r[k] <= '0;
            state_r     <= ST_ACC;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_ACC;
          cnt_r       <= 3'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          for (int k = 0; k < 8; k++) acc_r[k] <= '0;
        end
      endcase
    end
  end

  // Rounding shift is done one bit wider so the rounding constant can never wrap.
  genvar g;
  for (g = 0; g < 8; g++) begin : g_out
    assign r_s[g] = (RW'(acc_r[g]) + RND) >>> SHIFT;
    if (OUT_W >= RW) begin : g_wide
      assign y_s[g] = OUT_W'(r_s[g]);
    end else begin : g_sat
      localparam logic signed [RW-1:0] MAXV = RW'({1'b0, {(OUT_W-1){1'b1}}});
      localparam logic signed [RW-1:0] MINV = ~MAXV;
      assign y_s[g] = (r_s[g] > MAXV) ? MAXV[OUT_W-1:0] :
                      (r_s[g] < MINV) ? MINV[OUT_W-1:0] : r_s[g][OUT_W-1:0];
    end
    assign yo_s[g] = (state_r == ST_OUT) ? y_s[g] : '0;
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Y0 = yo_s[0];
  assign Y1 = yo_s[1];
  assign Y2 = yo_s[2];
  assign Y3 = yo_s[3];
  assign Y4 = yo_s[4];
  assign Y5 = yo_s[5];
  assign Y6 = yo_s[6];
  assign Y7 = yo_s[7];

endmodule

// File: tb/tb_dst7_8_acc.sv
// Bench for dst7_8_acc: three configurations share one stimulus stream and are checked every
// cycle against a sine-sign reference model, plus hand-computed literal results.
module tb_dst7_8_acc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, out_ready;
  logic signed [31:0] p [8];
  logic ir0, ir1, ir2, ov0, ov1, ov2;
  logic signed [31:0] y0 [8];
  logic signed [31:0] y1 [8];
  logic signed [7:0]  y2 [8];

  dst7_8_acc u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .P1(p[0]), .P2(p[1]), .P3(p[2]), .P4(p[3]), .P5(p[4]), .P6(p[5]), .P7(p[6]), .P8(p[7]),
    .out_valid(ov0), .out_ready(out_ready),
    .Y0(y0[0]), .Y1(y0[1]), .Y2(y0[2]), .Y3(y0[3]), .Y4(y0[4]), .Y5(y0[5]), .Y6(y0[6]), .Y7(y0[7]));
  dst7_8_acc #(.SHIFT(7)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .P1(p[0]), .P2(p[1]), .P3(p[2]), .P4(p[3]), .P5(p[4]), .P6(p[5]), .P7(p[6]), .P8(p[7]),
    .out_valid(ov1), .out_ready(out_ready),
    .Y0(y1[0]), .Y1(y1[1]), .Y2(y1[2]), .Y3(y1[3]), .Y4(y1[4]), .Y5(y1[5]), .Y6(y1[6]), .Y7(y1[7]));
  dst7_8_acc #(.OUT_W(8)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .P1(p[0]), .P2(p[1]), .P3(p[2]), .P4(p[3]), .P5(p[4]), .P6(p[5]), .P7(p[6]), .P8(p[7]),
    .out_valid(ov2), .out_ready(out_ready),
    .Y0(y2[0]), .Y1(y2[1]), .Y2(y2[2]), .Y3(y2[3]), .Y4(y2[4]), .Y5(y2[5]), .Y6(y2[6]), .Y7(y2[7]));

  int n_chk = 0, n_pass = 0, cyc = 0, last_lat = 0;
  bit started = 1'b0;
  longint cur_x = 0;
  longint bx [8];
  bit m_out = 1'b0;
  int m_cnt = 0;
  longint m_x [8];
  longint e_acc [8];

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic longint cmag(input int j);
    case (j)
      1: return 11;  2: return 22;  3: return 33;  4: return 42;
      5: return 50;  6: return 56;  7: return 60;  8: return 62;
      default: return 0;
    endcase
  endfunction

  // Basis weight: magnitude from the folded phase, sign from the sine of the true phase.
  function automatic longint coef(input int k, input int n);
    int prod, jm, j;
    real s;
    prod = (2 * k + 1) * (n + 1);
    jm = prod % 17;
    j = (jm <= 8) ? jm : 17 - jm;
    s = $sin(3.141592653589793 * real'(prod) / 17.0);
    return (s > 0.0) ? cmag(j) : -cmag(j);
  endfunction

  function automatic longint shape(input longint a, input int sh, input int ow);
    longint r, mx, mn;
    if (sh > 0) r = (a + (64'sd1 <<< (sh - 1))) >>> sh;
    else r = a;
    mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (r > mx) return mx;
    else if (r < mn) return mn;
    else return r;
  endfunction

  function automatic longint block_sum(input int k, input longint last);
    longint s = 0;
    for (int n = 0; n < 7; n++) s += coef(k, n) * m_x[n];
    return s + coef(k, 7) * last;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the block handshake and per-block result.
  always @(posedge clk) begin
    if (rst) begin
      m_out <= 1'b0;
      m_cnt <= 0;
    end else if (!m_out) begin
      if (in_valid) begin
        m_x[m_cnt] <= cur_x;
        if (m_cnt == 7) begin
          for (int k = 0; k < 8; k++) e_acc[k] <= block_sum(k, cur_x);
          m_out <= 1'b1;
          m_cnt <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (out_ready) begin
      m_out <= 1'b0;
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready0", longint'(ir0), longint'(!m_out));
      check("in_ready1", longint'(ir1), longint'(!m_out));
      check("in_ready2", longint'(ir2), longint'(!m_out));
      check("out_valid0", longint'(ov0), longint'(m_out));
      check("out_valid1", longint'(ov1), longint'(m_out));
      check("out_valid2", longint'(ov2), longint'(m_out));
      for (int k = 0; k < 8; k++) begin
        check($sformatf("y0[%0d]", k), longint'(y0[k]), m_out ? shape(e_acc[k], 0, 32) : 64'sd0);
        check($sformatf("y1[%0d]", k), longint'(y1[k]), m_out ? shape(e_acc[k], 7, 32) : 64'sd0);
        check($sformatf("y2[%0d]", k), longint'(y2[k]), m_out ? shape(e_acc[k], 0, 8) : 64'sd0);
      end
    end
  end

  task automatic drive_x(input longint x);
    cur_x = x;
    for (int j = 0; j < 8; j++) p[j] = 32'(x * cmag(j + 1));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    drive_x(0);
  endtask

  task automatic send_block(input bit gap);
    int first_cyc = 0;
    int w = 0;
    for (int n = 0; n < 8; n++) begin
      if (gap) begin
        repeat ($urandom_range(0, 3)) begin
          idle();
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      drive_x(bx[n]);
      if (n == 0) first_cyc = cyc;
      @(posedge clk); #1;
    end
    idle();
    while (!ov0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("out_valid_wait", longint'(ov0), 64'sd1);
    last_lat = cyc - first_cyc;
  endtask

  task automatic release_out(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_lit0(input string nm, input longint e0, input longint e1, input longint e2,
                            input longint e3, input longint e4, input longint e5, input longint e6,
                            input longint e7);
    longint e [8];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    for (int k = 0; k < 8; k++) check($sformatf("%s_y%0d", nm, k), longint'(y0[k]), e[k]);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    @(posedge clk); #1;
    started = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", longint'(ir0), 64'sd1);
    check("reset_out_valid", longint'(ov0), 64'sd0);
    check("reset_y0", longint'(y0[0]), 64'sd0);
    rst = 1'b0;

    // Impulse at n=0, with out_ready already high during accumulation.
    bx = '{1, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b1;
    send_block(1'b0);
    check_lit0("imp_first", 11, 33, 50, 60, 62, 56, 42, 22);
    release_out(0);
    check("single_pulse", longint'(ov0), 64'sd0);

    bx = '{0, 0, 0, 0, 0, 0, 0, 1};
    send_block(1'b0);
    check_lit0("imp_last", 62, -60, 56, -50, 42, -33, 22, -11);
    release_out(0);

    bx = '{1, 1, 1, 1, 1, 1, 1, 1};
    send_block(1'b0);
    check("dc_y0", longint'(y0[0]), 64'sd336);
    check("dc_latency", longint'(last_lat), 64'sd8);
    release_out(0);

    // Random input gaps, then the result is held back for five cycles.
    bx = '{3, -7, 12, 5, -1, 9, 0, 4};
    send_block(1'b1);
    release_out(5);

    bx = '{1, 0, 0, 0, 0, 0, 0, 0};
    send_block(1'b0);
    check_lit0("after_hold", 11, 33, 50, 60, 62, 56, 42, 22);
    release_out(0);

    bx = '{64, 0, 0, 0, 0, 0, 0, 0};
    send_block(1'b0);
    check("shift_y0", longint'(y1[0]), 64'sd6);
    check("noshift_y0", longint'(y0[0]), 64'sd704);
    release_out(0);

    bx = '{1048576, 1048576, 1048576, 1048576, 1048576, 1048576, 1048576, 1048576};
    send_block(1'b0);
    check("sat_pos_y0", longint'(y2[0]), 64'sd127);
    release_out(0);

    bx = '{-1048576, -1048576, -1048576, -1048576, -1048576, -1048576, -1048576, -1048576};
    send_block(1'b0);
    check("sat_neg_y0", longint'(y2[0]), -64'sd128);
    release_out(0);

    // Four samples accepted, then a reset throws them away.
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1;
      drive_x(100 + n);
      @(posedge clk); #1;
    end
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bx = '{1, 0, 0, 0, 0, 0, 0, 0};
    send_block(1'b0);
    check_lit0("post_reset", 11, 33, 50, 60, 62, 56, 42, 22);
    release_out(0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
